// File: rtl/pa_rtu_split_merge.sv
// Retire-side merge of LR/SC and AMO split uop streams into one architectural retire.
// Checks uop order, holds interrupt-disable across the sequence, reports expt/seq errors.
//
// state   | meaning
// IDLE    | no sequence open; waiting for FENCE_1
// COLLECT | sequence open; exp_st_q holds the next legal uop code
module pa_rtu_split_merge #(
  parameter int TIMEOUT_W = 8
) (
  input  logic       cpuclk,
  input  logic       cpurst,
  input  logic       rtu_flush,
  input  logic       ex_split_vld,
  input  logic [2:0] ex_split_st,
  input  logic       ex_split_amo,
  input  logic       ex_split_aq,
  input  logic       ex_split_expt,
  output logic       merge_busy,
  output logic       merge_int_dis,
  output logic       merge_retire_vld,
  output logic       merge_retire_amo,
  output logic [2:0] merge_uop_cnt,
  output logic       merge_expt_vld,
  output logic [2:0] merge_expt_st,
  output logic       merge_seq_err
);

  localparam logic [2:0] ST_FENCE_1 = 3'b000;
  localparam logic [2:0] ST_LLSC    = 3'b001;
  localparam logic [2:0] ST_AMO_LD  = 3'b010;
  localparam logic [2:0] ST_AMO_ALU = 3'b011;
  localparam logic [2:0] ST_AMO_ST  = 3'b100;
  localparam logic [2:0] ST_AMO_MOV = 3'b101;
  localparam logic [2:0] ST_FENCE_2 = 3'b110;

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e               state_q, state_d;
  logic [2:0]           exp_st_q, exp_st_d;
  logic                 amo_q, amo_d;
  logic                 aq_q, aq_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 retire_vld_q, retire_vld_d;
  logic                 retire_amo_q, retire_amo_d;
  logic [2:0]           uop_cnt_q, uop_cnt_d;
  logic                 expt_vld_q, expt_vld_d;
  logic [2:0]           expt_st_q, expt_st_d;
  logic                 seq_err_q, seq_err_d;

  logic [2:0]           seq_next;
  logic                 seq_last;
  logic [2:0]           cnt_inc;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic                 fence1_ok;

  assign cnt_inc   = cnt_q + 3'd1;
  assign wd_inc    = wd_q + TIMEOUT_W'(1);
  assign fence1_ok = ex_split_vld & (ex_split_st == ST_FENCE_1) & ~ex_split_expt;

  // Successor of the currently expected code; seq_last marks the closing uop.
  always_comb begin
    seq_next = exp_st_q;
    seq_last = 1'b0;
    case (exp_st_q)
      ST_AMO_LD:  seq_next = ST_AMO_ALU;
      ST_AMO_ALU: seq_next = ST_AMO_ST;
      ST_AMO_ST:  seq_next = ST_AMO_MOV;
      ST_LLSC, ST_AMO_MOV: begin
        if (aq_q) seq_next = ST_FENCE_2;
        else      seq_last = 1'b1;
      end
      default:    seq_last = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    exp_st_d     = exp_st_q;
    amo_d        = amo_q;
    aq_d         = aq_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    retire_vld_d = 1'b0;
    retire_amo_d = retire_amo_q;
    uop_cnt_d    = uop_cnt_q;
    expt_vld_d   = 1'b0;
    expt_st_d    = expt_st_q;
    seq_err_d    = 1'b0;

    if (rtu_flush) begin
      state_d = IDLE;
      wd_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fence1_ok) begin
            amo_d    = ex_split_amo;
            aq_d     = ex_split_aq;
            cnt_d    = 3'd1;
            exp_st_d = ex_split_amo ? ST_AMO_LD : ST_LLSC;
            wd_d     = '0;
            state_d  = COLLECT;
          end else if (ex_split_vld && ex_split_st == ST_FENCE_1) begin
            expt_vld_d = 1'b1;
            expt_st_d  = ST_FENCE_1;
            uop_cnt_d  = 3'd1;
          end else if (ex_split_vld) begin
            seq_err_d = 1'b1;
            uop_cnt_d = 3'd1;
          end
        end
        COLLECT: begin
          if (ex_split_vld) begin
            cnt_d = cnt_inc;
            wd_d  = '0;
            if (ex_split_st != exp_st_q) begin
              seq_err_d = 1'b1;
              uop_cnt_d = cnt_inc;
              state_d   = IDLE;
            end else if (ex_split_expt) begin
              expt_vld_d = 1'b1;
              expt_st_d  = ex_split_st;
              uop_cnt_d  = cnt_inc;
              state_d    = IDLE;
            end else if (seq_last) begin
              retire_vld_d = 1'b1;
              retire_amo_d = amo_q;
              uop_cnt_d    = cnt_inc;
              state_d      = IDLE;
            end else begin
              exp_st_d = seq_next;
            end
          end else begin
            wd_d = wd_inc;
            // Watchdog expiry closes the sequence with the uops seen so far.
            if (wd_inc == '1) begin
              seq_err_d = 1'b1;
              uop_cnt_d = cnt_q;
              wd_d      = '0;
              state_d   = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge cpuclk) begin
    if (cpurst) begin
      state_q      <= IDLE;
      exp_st_q     <= '0;
      amo_q        <= 1'b0;
      aq_q         <= 1'b0;
      cnt_q        <= '0;
      wd_q         <= '0;
      retire_vld_q <= 1'b0;
      retire_amo_q <= 1'b0;
      uop_cnt_q    <= '0;
      expt_vld_q   <= 1'b0;
      expt_st_q    <= '0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_st_q     <= exp_st_d;
      amo_q        <= amo_d;
      aq_q         <= aq_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      retire_vld_q <= retire_vld_d;
      retire_amo_q <= retire_amo_d;
      uop_cnt_q    <= uop_cnt_d;
      expt_vld_q   <= expt_vld_d;
      expt_st_q    <= expt_st_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign merge_busy       = (state_q == COLLECT);
  assign merge_int_dis    = merge_busy | ((state_q == IDLE) & fence1_ok);
  assign merge_retire_vld = retire_vld_q;
  assign merge_retire_amo = retire_amo_q;
  assign merge_uop_cnt    = uop_cnt_q;
  assign merge_expt_vld   = expt_vld_q;
  assign merge_expt_st    = expt_st_q;
  assign merge_seq_err    = seq_err_q;

endmodule

// File: tb/tb_pa_rtu_split_merge.sv
// Bench for pa_rtu_split_merge: directed scenarios plus random traffic, all checked
// against a sequence-list reference model of the split/merge rules.
module tb_pa_rtu_split_merge;

  localparam int TW      = 3;
  localparam int WD_IDLE = (1 << TW) - 1;

  logic       cpuclk;
  logic       cpurst;
  logic       rtu_flush;
  logic       ex_split_vld;
  logic [2:0] ex_split_st;
  logic       ex_split_amo;
  logic       ex_split_aq;
  logic       ex_split_expt;
  logic       merge_busy;
  logic       merge_int_dis;
  logic       merge_retire_vld;
  logic       merge_retire_amo;
  logic [2:0] merge_uop_cnt;
  logic       merge_expt_vld;
  logic [2:0] merge_expt_st;
  logic       merge_seq_err;

  pa_rtu_split_merge #(.TIMEOUT_W(TW)) dut (
    .cpuclk(cpuclk), .cpurst(cpurst), .rtu_flush(rtu_flush),
    .ex_split_vld(ex_split_vld), .ex_split_st(ex_split_st),
    .ex_split_amo(ex_split_amo), .ex_split_aq(ex_split_aq),
    .ex_split_expt(ex_split_expt),
    .merge_busy(merge_busy), .merge_int_dis(merge_int_dis),
    .merge_retire_vld(merge_retire_vld), .merge_retire_amo(merge_retire_amo),
    .merge_uop_cnt(merge_uop_cnt), .merge_expt_vld(merge_expt_vld),
    .merge_expt_st(merge_expt_st), .merge_seq_err(merge_seq_err)
  );

  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic       vld;
    logic [2:0] st;
    logic       amo;
    logic       aq;
    logic       expt;
  } stim_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an open sequence is the list of codes still owed.
  logic       m_open = 1'b0;
  logic [2:0] m_list[$];
  logic       m_amo = 1'b0;
  int         m_n = 0;
  int         m_idle = 0;
  logic       e_retire = 1'b0, e_ramo = 1'b0, e_expt = 1'b0, e_err = 1'b0;
  logic [2:0] e_cnt = 3'd0, e_expt_st = 3'd0;
  logic       e_int_dis = 1'b0;
  logic       obs_int_dis;

  function automatic stim_t mk(input logic vld, input logic [2:0] st,
                               input logic amo = 1'b0, input logic aq = 1'b0,
                               input logic expt = 1'b0, input logic flush = 1'b0,
                               input logic rst = 1'b0);
    stim_t s;
    s.rst = rst; s.flush = flush; s.vld = vld; s.st = st;
    s.amo = amo; s.aq = aq; s.expt = expt;
    return s;
  endfunction

  function automatic logic [10:0] obs_vec();
    return {merge_busy, merge_retire_vld, merge_retire_amo, merge_uop_cnt,
            merge_expt_vld, merge_expt_st, merge_seq_err};
  endfunction

  function automatic logic [10:0] exp_vec();
    return {m_open, e_retire, e_ramo, e_cnt, e_expt, e_expt_st, e_err};
  endfunction

  task automatic model_step(input stim_t s);
    e_retire = 1'b0; e_expt = 1'b0; e_err = 1'b0;
    if (s.rst) begin
      m_open = 1'b0; m_list.delete(); m_idle = 0; m_n = 0;
      e_ramo = 1'b0; e_cnt = 3'd0; e_expt_st = 3'd0;
    end else if (s.flush) begin
      m_open = 1'b0; m_list.delete();
    end else if (!m_open) begin
      if (s.vld && s.st != 3'd0) begin
        e_err = 1'b1; e_cnt = 3'd1;
      end else if (s.vld && s.expt) begin
        e_expt = 1'b1; e_expt_st = 3'd0; e_cnt = 3'd1;
      end else if (s.vld) begin
        m_open = 1'b1; m_amo = s.amo; m_n = 1; m_idle = 0; m_list.delete();
        if (s.amo) begin
          m_list.push_back(3'd2); m_list.push_back(3'd3);
          m_list.push_back(3'd4); m_list.push_back(3'd5);
        end else begin
          m_list.push_back(3'd1);
        end
        if (s.aq) m_list.push_back(3'd6);
      end
    end else if (s.vld) begin
      m_n++; m_idle = 0;
      if (s.st != m_list[0]) begin
        e_err = 1'b1; e_cnt = 3'(m_n); m_open = 1'b0;
      end else if (s.expt) begin
        e_expt = 1'b1; e_expt_st = s.st; e_cnt = 3'(m_n); m_open = 1'b0;
      end else begin
        void'(m_list.pop_front());
        if (m_list.size() == 0) begin
          e_retire = 1'b1; e_ramo = m_amo; e_cnt = 3'(m_n); m_open = 1'b0;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == WD_IDLE) begin
        e_err = 1'b1; e_cnt = 3'(m_n); m_open = 1'b0;
      end
    end
  endtask

  // Drive one cycle: inputs at negedge, sample int_dis mid-cycle, land #1 after posedge.
  task automatic step(input stim_t s);
    @(negedge cpuclk);
    cpurst = s.rst; rtu_flush = s.flush; ex_split_vld = s.vld; ex_split_st = s.st;
    ex_split_amo = s.amo; ex_split_aq = s.aq; ex_split_expt = s.expt;
    e_int_dis = m_open || (s.vld && s.st == 3'd0 && !s.expt);
    model_step(s);
    #1;
    obs_int_dis = merge_int_dis;
    @(posedge cpuclk);
    #1;
  endtask

  task automatic test_reset();
    stim_t q[$];
    q.push_back(mk(1, 3'd0, 1)); q.push_back(mk(1, 3'd2));
    q.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1)); q.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1));
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_int_dis !== e_int_dis)
        $display("FAIL reset int_dis step %0d: got %b want %b", i, obs_int_dis, e_int_dis);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL reset outputs step %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (obs_vec() !== 11'd0 || merge_int_dis !== 1'b0)
      $display("FAIL reset values: got %b int_dis %b want all zero", obs_vec(), merge_int_dis);
    else n_pass++;
  endtask

  task automatic test_amo_no_gap();
    stim_t q[$];
    q.push_back(mk(1, 3'd0, 1, 0)); q.push_back(mk(1, 3'd2)); q.push_back(mk(1, 3'd3));
    q.push_back(mk(1, 3'd4)); q.push_back(mk(1, 3'd5)); q.push_back(mk(0, 3'd0));
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_int_dis !== e_int_dis)
        $display("FAIL amo int_dis step %0d: got %b want %b", i, obs_int_dis, e_int_dis);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL amo outputs step %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (merge_retire_vld !== 1'b1 || merge_retire_amo !== 1'b1 || merge_uop_cnt !== 3'd5)
          $display("FAIL amo retire: got vld %b amo %b cnt %0d want 1 1 5",
                   merge_retire_vld, merge_retire_amo, merge_uop_cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lr_aq_gaps();
    stim_t q[$];
    q.push_back(mk(1, 3'd0, 0, 1)); q.push_back(mk(0, 3'd0)); q.push_back(mk(0, 3'd0));
    q.push_back(mk(1, 3'd1)); q.push_back(mk(0, 3'd0)); q.push_back(mk(0, 3'd0));
    q.push_back(mk(1, 3'd6)); q.push_back(mk(0, 3'd0));
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_int_dis !== e_int_dis)
        $display("FAIL lr_aq int_dis step %0d: got %b want %b", i, obs_int_dis, e_int_dis);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL lr_aq outputs step %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == 6) begin
        n_checks++;
        if (merge_retire_vld !== 1'b1 || merge_retire_amo !== 1'b0 ||
            merge_uop_cnt !== 3'd3 || merge_seq_err !== 1'b0)
          $display("FAIL lr_aq retire: got vld %b amo %b cnt %0d err %b want 1 0 3 0",
                   merge_retire_vld, merge_retire_amo, merge_uop_cnt, merge_seq_err);
        else n_pass++;
      end
    end
  endtask

  task automatic test_amo_expt();
    stim_t q[$];
    q.push_back(mk(1, 3'd0, 1)); q.push_back(mk(1, 3'd2)); q.push_back(mk(1, 3'd3));
    q.push_back(mk(1, 3'd4, 0, 0, 1)); q.push_back(mk(0, 3'd0)); q.push_back(mk(1, 3'd0, 0, 0, 1));
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_int_dis !== e_int_dis)
        $display("FAIL expt int_dis step %0d: got %b want %b", i, obs_int_dis, e_int_dis);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL expt outputs step %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (merge_expt_vld !== 1'b1 || merge_expt_st !== 3'd4 || merge_uop_cnt !== 3'd4 ||
            merge_busy !== 1'b0 || merge_retire_vld !== 1'b0)
          $display("FAIL expt pulse: got vld %b st %0d cnt %0d busy %b ret %b want 1 4 4 0 0",
                   merge_expt_vld, merge_expt_st, merge_uop_cnt, merge_busy, merge_retire_vld);
        else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    stim_t q[$];
    q.push_back(mk(1, 3'd0, 1)); q.push_back(mk(1, 3'd3)); q.push_back(mk(0, 3'd0));
    q.push_back(mk(1, 3'd1)); q.push_back(mk(0, 3'd0));
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_int_dis !== e_int_dis)
        $display("FAIL illegal int_dis step %0d: got %b want %b", i, obs_int_dis, e_int_dis);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL illegal outputs step %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == 1 || i == 3) begin
        n_checks++;
        if (merge_seq_err !== 1'b1 || merge_uop_cnt !== ((i == 1) ? 3'd2 : 3'd1))
          $display("FAIL illegal seq_err step %0d: got err %b cnt %0d", i,
                   merge_seq_err, merge_uop_cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_watchdog();
    stim_t q[$];
    q.push_back(mk(1, 3'd0, 0, 0));
    for (int k = 0; k < 9; k++) q.push_back(mk(0, 3'd0));
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_int_dis !== e_int_dis)
        $display("FAIL watchdog int_dis step %0d: got %b want %b", i, obs_int_dis, e_int_dis);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL watchdog outputs step %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == WD_IDLE) begin
        n_checks++;
        if (merge_seq_err !== 1'b1 || merge_uop_cnt !== 3'd1 || merge_busy !== 1'b0)
          $display("FAIL watchdog fire: got err %b cnt %0d busy %b want 1 1 0",
                   merge_seq_err, merge_uop_cnt, merge_busy);
        else n_pass++;
      end
    end
  endtask

  task automatic test_flush_reset();
    stim_t q[$];
    q.push_back(mk(1, 3'd0, 1)); q.push_back(mk(1, 3'd2)); q.push_back(mk(1, 3'd3));
    q.push_back(mk(1, 3'd4)); q.push_back(mk(1, 3'd5, 0, 0, 0, 1));
    q.push_back(mk(1, 3'd0, 0, 0)); q.push_back(mk(1, 3'd1)); q.push_back(mk(0, 3'd0));
    q.push_back(mk(1, 3'd0, 1, 1)); q.push_back(mk(1, 3'd2));
    q.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 3'd0, 0, 0)); q.push_back(mk(1, 3'd1)); q.push_back(mk(0, 3'd0));
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_int_dis !== e_int_dis)
        $display("FAIL flush_rst int_dis step %0d: got %b want %b", i, obs_int_dis, e_int_dis);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL flush_rst outputs step %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (merge_retire_vld !== 1'b0 || merge_busy !== 1'b0 || merge_seq_err !== 1'b0)
          $display("FAIL flush collision: got ret %b busy %b err %b want 0 0 0",
                   merge_retire_vld, merge_busy, merge_seq_err);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    q.push_back(mk(1, 3'd0, 0, 0)); q.push_back(mk(1, 3'd1));
    q.push_back(mk(1, 3'd0, 0, 0)); q.push_back(mk(1, 3'd1));
    q.push_back(mk(1, 3'd0, 1, 1)); q.push_back(mk(1, 3'd2)); q.push_back(mk(1, 3'd3));
    q.push_back(mk(1, 3'd4)); q.push_back(mk(1, 3'd5)); q.push_back(mk(1, 3'd6));
    q.push_back(mk(0, 3'd0));
    foreach (q[i]) begin
      step(q[i]);
      n_checks++;
      if (obs_int_dis !== e_int_dis)
        $display("FAIL b2b int_dis step %0d: got %b want %b", i, obs_int_dis, e_int_dis);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL b2b outputs step %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    stim_t s;
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      s = mk(0, 3'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (r < 58) begin
        s.vld = 1'b1;
        s.st = m_open ? m_list[0] : 3'd0;
        if ($urandom_range(0, 19) == 0) s.st = 3'($urandom_range(0, 6));
        s.expt = ($urandom_range(0, 24) == 0);
      end else if (r < 97) begin
        s.vld = 1'b0;
      end else if (r < 99) begin
        s.flush = 1'b1;
        s.vld = 1'($urandom_range(0, 1));
        s.st = m_open ? m_list[0] : 3'd0;
      end else begin
        s.rst = 1'b1;
      end
      step(s);
      n_checks++;
      if (obs_int_dis !== e_int_dis)
        $display("FAIL random int_dis step %0d: got %b want %b", i, obs_int_dis, e_int_dis);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random outputs step %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    cpurst = 1'b1; rtu_flush = 1'b0; ex_split_vld = 1'b0; ex_split_st = 3'd0;
    ex_split_amo = 1'b0; ex_split_aq = 1'b0; ex_split_expt = 1'b0;
    repeat (2) @(posedge cpuclk);
    test_reset();
    test_amo_no_gap();
    test_lr_aq_gaps();
    test_amo_expt();
    test_illegal();
    test_watchdog();
    test_flush_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pa_rtu_split_merge.md
# pa_rtu_split_merge

Retire-side companion to the IDU atomic split FSM. It consumes the micro-op stream the decoder emits for LR/SC and AMO instructions, checks the stream against the legal split sequence, and collapses each completed sequence into one architectural retire. It holds the interrupt-disable request for the whole sequence, and reports exceptions, sequence violations and stalls. It sits in the RTU, fed by the EX1 retire port.

## Interface
Parameters:
- TIMEOUT_W, default 8: width of the inter-uop watchdog counter. Abort fires at 2^TIMEOUT_W−1 idle cycles.

Ports:
- cpuclk  in  1  core clock.
- cpurst  in  1  reset, synchronous and active-high.
- rtu_flush  in  1  pipeline flush. Aborts silently.
- ex_split_vld  in  1  a split uop retires from EX1 this cycle.
- ex_split_st  in  3  split state code of that uop: FENCE_1=000, LLSC=001, AMO_LD=010, AMO_ALU=011, AMO_ST=100, AMO_MOV=101, FENCE_2=110.
- ex_split_amo  in  1  the parent instruction is an AMO (0 = LR/SC). Sampled only on FENCE_1.
- ex_split_aq  in  1  the parent has the aq bit set. Sampled only on FENCE_1.
- ex_split_expt  in  1  this uop raised an exception.
- merge_busy  out  1  a sequence is open (registered).
- merge_int_dis  out  1  interrupt-disable request to the IDU.
- merge_retire_vld  out  1  one-cycle pulse: the parent instruction retires.
- merge_retire_amo  out  1  the retired parent was an AMO. Valid with retire_vld.
- merge_uop_cnt  out  3  number of uops accepted in the sequence just closed. Valid with any closing pulse.
- merge_expt_vld  out  1  one-cycle pulse: the sequence ended on an exception.
- merge_expt_st  out  3  split code of the faulting uop.
- merge_seq_err  out  1  one-cycle pulse: illegal order or watchdog timeout.

## Operation
- The FSM has two states: IDLE and COLLECT. It holds `exp_st[2:0]`, `amo_q`, `aq_q`, `cnt[2:0]` and `wd[TIMEOUT_W-1:0]`.
- **IDLE**
  - A uop with ex_split_st=FENCE_1 and no exception: latch amo_q and aq_q, set cnt=1, set exp_st = amo ? AMO_LD : LLSC, clear wd, go to COLLECT.
  - FENCE_1 with an exception: pulse expt with cnt=1, stay in IDLE.
  - Any other code: pulse seq_err with cnt=1, stay in IDLE.
- **COLLECT, uop with ex_split_st == exp_st**
  - cnt increments and wd clears.
  - If the uop has an exception: pulse expt_vld, set expt_st to the uop's code, go to IDLE.
  - Otherwise advance exp_st along the sequence:
    - FENCE_1 → LLSC (amo_q=0) or AMO_LD (amo_q=1).
    - AMO_LD → AMO_ALU → AMO_ST → AMO_MOV.
    - LLSC or AMO_MOV → FENCE_2 if aq_q=1; otherwise this uop is the last.
    - FENCE_2 is always the last.
  - On the last uop: pulse retire_vld with retire_amo=amo_q, go to IDLE.
- **COLLECT, uop with ex_split_st != exp_st**: pulse seq_err and go to IDLE. cnt in the pulse includes the bad uop.
- **COLLECT, no uop**: wd increments. When wd reaches all-ones, pulse seq_err with the current cnt and go to IDLE.
- **Sequence lengths**: LR/SC is 2 uops (3 with aq). AMO is 5 uops (6 with aq). cnt never exceeds 6.
- **merge_int_dis** = merge_busy OR (IDLE & ex_split_vld & st==FENCE_1 & ~expt). The combinational term covers the accept cycle.
- **Priority**: cpurst > rtu_flush > uop handling > watchdog.
  - A flush in any cycle forces IDLE and suppresses every pulse for that cycle.
  - Flush together with the final uop: no retire.

## Timing
- All outputs except merge_int_dis are registered. A uop accepted at cycle t produces its pulse at t+1.
- merge_busy rises at t+1 after FENCE_1 is accepted. It falls at t+1 after the closing uop.
- Back-to-back sequences are legal: the next FENCE_1 can arrive in the same cycle that the previous retire pulse is high.
- Reset values: merge_busy=0, merge_int_dis=0, every pulse 0, merge_retire_amo=0, merge_uop_cnt=0, merge_expt_st=0. FSM state IDLE, wd=0.
- Reset mid-sequence: back to IDLE on the next edge, with no pulse.
- Pulses are exactly one cycle wide. At most one of retire, expt and seq_err is high in any cycle.
- merge_uop_cnt and merge_expt_st hold their values until the next closing event.

## Test plan
- **AMO, aq=0, no gaps**: uops 000,010,011,100,101 on consecutive cycles → retire_vld=1 and retire_amo=1 one cycle after 101, uop_cnt=5. int_dis is high from the 000 cycle through the 101 cycle.
- **LR, aq=1, two idle cycles between uops**: 000, 001, 110 → retire_vld with retire_amo=0 and uop_cnt=3. No seq_err.
- **AMO with exception on AMO_ST**: 000,010,011,100 with expt=1 on 100 → expt_vld=1, expt_st=100, uop_cnt=4. busy=0 on the next cycle, and no retire.
- **Illegal order**: 000 (amo=1) then 011 → seq_err=1 with uop_cnt=2. A lone 001 in IDLE → seq_err with uop_cnt=1.
- **Watchdog**: TIMEOUT_W=3, send 000 and then nothing → seq_err 7 idle cycles later (wd reaches 7). int_dis drops the following cycle.
- **Flush collision and reset**:
  - rtu_flush asserted in the same cycle as the final 101 → no pulse, busy=0.
  - cpurst asserted mid-sequence → all outputs at reset values.
  - A new 000 one cycle after either → accepted normally.
